// File: rtl/tm_pkg.sv
// Shared definitions for the TuringMachine control front-end and core.
package tm_pkg;

   localparam int TM_DATA_W  = 4;
   localparam int TM_FIELDS  = 4;
   localparam int TM_ENTRIES = 16;

   typedef enum logic [1:0] {
      S_LOAD = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } seq_state_t;

endpackage

// File: rtl/tm_btn_sync.sv
// Two-flop synchroniser for an asynchronous button level, followed by a
// registered rising-edge detector: one single-cycle pulse per press.
module tm_btn_sync (
   input  logic clock,
   input  logic reset,
   input  logic btn,
   output logic pulse
);

   // sh[0], sh[1] synchronise; sh[2] remembers the previous synchronised level
   logic [2:0] sh;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sh    <= '0;
         pulse <= 1'b0;
      end else begin
         sh    <= {sh[1:0], btn};
         pulse <= sh[1] & ~sh[2];
      end
   end

endmodule

// File: rtl/tm_run_sequencer.sv
// Control front-end for the TuringMachine core: turns button presses and data
// switches into table writes, then issues manual or timed step pulses until halt.
module tm_run_sequencer
   import tm_pkg::*;
#(
   parameter  int DATA_W  = TM_DATA_W,
   parameter  int FIELDS  = TM_FIELDS,
   parameter  int ENTRIES = TM_ENTRIES,
   parameter  int RATE_W  = 8,
   localparam int ADDR_W  = $clog2(ENTRIES)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [DATA_W-1:0]        data_in,
   input  logic                     next_in,
   input  logic                     done_in,
   input  logic                     auto_run,
   input  logic [RATE_W-1:0]        rate,
   input  logic                     halted,
   output logic                     tbl_we,
   output logic [ADDR_W-1:0]        tbl_addr,
   output logic [FIELDS*DATA_W-1:0] tbl_wdata,
   output logic                     step,
   output logic [1:0]               phase,
   output logic [ADDR_W:0]          entry_count,
   output logic [15:0]              step_count,
   output logic                     load_err
);

   localparam int IDX_W = $clog2(FIELDS);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(FIELDS - 1);
   localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(ENTRIES);

   logic                           next_p;
   logic                           done_p;
   seq_state_t                     state;
   logic [IDX_W-1:0]               idx;
   logic [FIELDS-2:0][DATA_W-1:0]  fld;
   logic [RATE_W-1:0]              tmr;
   logic                           tmr_armed;
   logic                           step_r;
   logic [RATE_W-1:0]              period_m1;

   tm_btn_sync u_next_sync (
      .clock (clock),
      .reset (reset),
      .btn   (next_in),
      .pulse (next_p)
   );

   tm_btn_sync u_done_sync (
      .clock (clock),
      .reset (reset),
      .btn   (done_in),
      .pulse (done_p)
   );

   // rate==0 behaves like rate==1 (step every cycle)
   assign period_m1 = (rate == '0) ? '0 : rate - RATE_W'(1);

   // halted can rise in the same cycle a registered step is due; mask it here
   assign step  = step_r & ~halted;
   assign phase = state;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= S_LOAD;
         idx         <= '0;
         fld         <= '0;
         tmr         <= '0;
         tmr_armed   <= 1'b0;
         step_r      <= 1'b0;
         tbl_we      <= 1'b0;
         tbl_addr    <= '0;
         tbl_wdata   <= '0;
         entry_count <= '0;
         step_count  <= '0;
         load_err    <= 1'b0;
      end else begin
         tbl_we <= 1'b0;
         step_r <= 1'b0;

         if (step && step_count != 16'hFFFF)
            step_count <= step_count + 16'd1;

         case (state)
            S_LOAD: begin
               // Done wins over a coincident Next
               if (done_p) begin
                  state <= S_RUN;
                  if (idx != '0)
                     load_err <= 1'b1;
                  idx <= '0;
               end else if (next_p) begin
                  if (idx == IDX_LAST) begin
                     idx <= '0;
                     if (entry_count == CNT_FULL) begin
                        load_err <= 1'b1;
                     end else begin
                        tbl_we      <= 1'b1;
                        tbl_addr    <= entry_count[ADDR_W-1:0];
                        tbl_wdata   <= {data_in, fld};
                        entry_count <= entry_count + (ADDR_W + 1)'(1);
                     end
                  end else begin
                     fld[idx] <= data_in;
                     idx      <= idx + IDX_W'(1);
                  end
               end
            end

            S_RUN: begin
               if (halted) begin
                  state     <= S_HALT;
                  tmr_armed <= 1'b0;
               end else if (auto_run) begin
                  if (!tmr_armed) begin
                     tmr       <= period_m1;
                     tmr_armed <= 1'b1;
                  end else if (tmr == '0) begin
                     step_r <= 1'b1;
                     tmr    <= period_m1;
                  end else begin
                     tmr <= tmr - RATE_W'(1);
                  end
               end else begin
                  tmr_armed <= 1'b0;
                  if (next_p)
                     step_r <= 1'b1;
               end
            end

            default: begin
               state <= S_HALT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tm_run_sequencer.sv
// Randomised bench for tm_run_sequencer against a press-level behavioural model.
module tb_tm_run_sequencer;
   import tm_pkg::*;

   localparam int DATA_W = 4, FIELDS = 4, ENTRIES = 16, RATE_W = 8, ADDR_W = 4;

   logic                     clock, reset;
   logic [DATA_W-1:0]        data_in;
   logic                     next_in, done_in, auto_run, halted;
   logic [RATE_W-1:0]        rate;
   logic                     tbl_we, step, load_err;
   logic [ADDR_W-1:0]        tbl_addr;
   logic [FIELDS*DATA_W-1:0] tbl_wdata;
   logic [1:0]               phase;
   logic [ADDR_W:0]          entry_count;
   logic [15:0]              step_count;

   tm_run_sequencer dut (
      .clock(clock), .reset(reset), .data_in(data_in), .next_in(next_in),
      .done_in(done_in), .auto_run(auto_run), .rate(rate), .halted(halted),
      .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata), .step(step),
      .phase(phase), .entry_count(entry_count), .step_count(step_count),
      .load_err(load_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int total = 0, bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // ---------------- monitor ----------------
   typedef struct { logic [3:0] a; logic [15:0] d; } wr_t;
   wr_t wr_q[$];
   wr_t exp_q[$];
   int  step_cyc[$];
   int  step_hi = 0, step_rise = 0, cyc = 0;
   logic step_d = 1'b0;

   always @(posedge clock) cyc++;

   always @(negedge clock) begin
      if (tbl_we) wr_q.push_back('{a: tbl_addr, d: tbl_wdata});
      if (step) begin
         step_hi++;
         step_cyc.push_back(cyc);
         if (!step_d) step_rise++;
         chk("step_while_halted", halted, 0);
      end
      if (tbl_we || step) chk("we_step_excl", tbl_we & step, 0);
      step_d = step;
   end

   // ---------------- behavioural model ----------------
   int       m_idx, m_cnt, m_phase, m_steps;
   bit       m_err;
   logic [3:0] m_fld[3];

   task automatic model_reset();
      m_idx = 0; m_cnt = 0; m_phase = 0; m_steps = 0; m_err = 0;
      exp_q.delete();
   endtask

   task automatic model_next(input logic [3:0] d);
      if (m_phase == 0) begin
         if (m_idx == FIELDS - 1) begin
            if (m_cnt == ENTRIES) m_err = 1;
            else begin
               exp_q.push_back('{a: 4'(m_cnt), d: {d, m_fld[2], m_fld[1], m_fld[0]}});
               m_cnt++;
            end
            m_idx = 0;
         end else begin
            m_fld[m_idx] = d;
            m_idx++;
         end
      end else if (m_phase == 1 && !auto_run && !halted) begin
         m_steps++;
      end
   endtask

   task automatic press(input bit nx, input bit dn, input int hold);
      @(negedge clock);
      next_in = nx; done_in = dn;
      repeat (hold) @(negedge clock);
      next_in = 1'b0; done_in = 1'b0;
      repeat (5) @(negedge clock);
   endtask

   task automatic next_field(input logic [3:0] d, input int hold);
      data_in = d;
      model_next(d);
      press(1'b1, 1'b0, hold);
   endtask

   task automatic do_done();
      if (m_phase == 0) begin
         if (m_idx != 0) m_err = 1;
         m_idx = 0;
         m_phase = 1;
      end
      press(1'b0, 1'b1, 1 + $urandom_range(3));
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      model_reset();
      wr_q.delete();
   endtask

   task automatic check_writes(input string tag);
      chk({tag, "_n"}, wr_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
         chk({tag, "_addr"}, wr_q[i].a, exp_q[i].a);
         chk({tag, "_data"}, wr_q[i].d, exp_q[i].d);
      end
      wr_q.delete();
      exp_q.delete();
   endtask

   task automatic check_period(input string tag, input int p);
      chk({tag, "_enough"}, step_cyc.size() >= 4, 1);
      for (int i = 1; i < step_cyc.size(); i++)
         chk(tag, step_cyc[i] - step_cyc[i-1], p);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [3:0] t1 [8];
      int n, snap, r;
      t1 = '{4'd3, 4'd1, 4'd0, 4'd2, 4'd1, 4'd0, 4'd1, 4'd0};
      reset = 1'b0; data_in = '0; next_in = 0; done_in = 0;
      auto_run = 0; halted = 0; rate = '0;
      model_reset();
      repeat (3) @(negedge clock);
      chk("rst_phase", phase, S_LOAD);
      chk("rst_we", tbl_we, 0);
      chk("rst_step", step, 0);
      chk("rst_cnt", entry_count, 0);
      chk("rst_steps", step_count, 0);
      chk("rst_err", load_err, 0);
      reset = 1'b1;

      // directed two-entry load
      foreach (t1[i]) next_field(t1[i], 1 + $urandom_range(2));
      chk("t1_q_data0", (exp_q.size() == 2) ? {16'h0, exp_q[0].d} : 32'hDEAD, 32'h2013);
      check_writes("t1");
      chk("t1_cnt", entry_count, m_cnt);
      chk("t1_err", load_err, 0);

      // random entries with random hold lengths
      n = $urandom_range(1, 3);
      for (int i = 0; i < n * FIELDS; i++) next_field(4'($urandom), 1 + $urandom_range(7));
      check_writes("rnd");
      chk("rnd_cnt", entry_count, m_cnt);

      // partial entry then Done
      next_field(4'($urandom), 2);
      next_field(4'($urandom), 2);
      do_done();
      chk("t2_phase", phase, S_RUN);
      chk("t2_err", load_err, m_err);
      check_writes("t2");

      // manual stepping
      step_hi = 0; step_rise = 0;
      for (int i = 0; i < 3; i++) next_field(4'($urandom), 1 + $urandom_range(2));
      chk("t3_steps", step_count, m_steps);
      chk("t3_width", step_hi, 3);
      next_field(4'd0, 10);
      chk("t3_hold", step_count, m_steps);
      chk("t3_hold_pulses", step_rise, step_hi);
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) next_field(4'($urandom), 1 + $urandom_range(5));
      chk("t3_rnd", step_count, m_steps);
      chk("t3_rnd_pulses", step_hi, m_steps);

      // free-run, rate 4, with an ignored Next press in the middle
      rate = 8'd4;
      step_cyc.delete();
      @(negedge clock) auto_run = 1'b1;
      repeat (12) @(negedge clock);
      press(1'b1, 1'b0, 2);
      repeat (20) @(negedge clock);
      auto_run = 1'b0;
      repeat (3) @(negedge clock);
      check_period("t4_rate4", 4);
      chk("t4_count", step_count, step_hi);

      // free-run at a random rate (0 behaves as 1)
      r = $urandom_range(0, 7);
      rate = 8'(r);
      step_cyc.delete();
      @(negedge clock) auto_run = 1'b1;
      repeat (40) @(negedge clock);
      check_period("t4_rnd", (r == 0) ? 1 : r);

      // halt
      halted = 1'b1;
      m_phase = 2;
      auto_run = 1'b0;
      repeat (3) @(negedge clock);
      chk("t4_halt_phase", phase, S_HALT);
      chk("t4_halt_count", step_count, step_hi);
      snap = step_hi;
      auto_run = 1'b1;
      halted = 1'b0;
      press(1'b1, 1'b0, 2);
      do_done();
      repeat (10) @(negedge clock);
      chk("t4_no_steps", step_hi, snap);
      chk("t4_steps_hold", step_count, snap);
      chk("t4_absorb", phase, S_HALT);
      auto_run = 1'b0;

      // overflow
      do_reset();
      for (int i = 0; i < (ENTRIES + 1) * FIELDS; i++) next_field(4'($urandom), 1);
      chk("t5_expn", exp_q.size(), ENTRIES);
      check_writes("t5");
      chk("t5_cnt", entry_count, ENTRIES);
      chk("t5_err", load_err, 1);

      // async reset mid-load
      do_reset();
      for (int i = 0; i < FIELDS + 2; i++) next_field(4'($urandom), 1);
      chk("t6_pre_cnt", entry_count, m_cnt);
      @(posedge clock);
      #2 reset = 1'b0;
      #1;
      chk("t6_async_cnt", entry_count, 0);
      chk("t6_async_addr", tbl_addr, 0);
      chk("t6_async_data", tbl_wdata, 0);
      chk("t6_async_phase", phase, S_LOAD);
      @(negedge clock) reset = 1'b1;
      model_reset();
      wr_q.delete();
      for (int i = 0; i < FIELDS; i++) next_field(4'($urandom), 1 + $urandom_range(3));
      check_writes("t6");
      chk("t6_cnt", entry_count, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      bad++;
      $display("FAIL watchdog: got timeout want finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
